// File: rtl/axi_sub_responder.sv
// Single-beat AXI subordinate backed by a small word memory, with per-channel
// enables, handshake pulses and capture of the last address/data seen.
//
//   state  | meaning
//   W_IDLE | collecting AW and W (either order), commit when both are held
//   W_RESP | write committed, B response offered / waiting for BREADY
//   R_IDLE | waiting for AR
//   R_DATA | read data captured, R beat offered / waiting for RREADY
module axi_sub_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY,
    input  logic [4:0]          tx_en,
    output logic [4:0]          new_data,
    output logic [ADDR_W-1:0]   sub_rx_AW,
    output logic [DATA_W-1:0]   sub_rx_W,
    output logic [ADDR_W-1:0]   sub_rx_AR
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t            w_state_q;
    r_state_t            r_state_q;
    logic                aw_held_q, w_held_q;
    logic [IDX_W-1:0]    aw_idx_q;
    logic                aw_ok_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                b_stuck_q, r_stuck_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [4:0]          new_data_q;
    logic [ADDR_W-1:0]   rx_aw_q, rx_ar_q;
    logic [DATA_W-1:0]   rx_w_q;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                aw_ok, ar_ok, commit;
    logic [IDX_W-1:0]    aw_idx, ar_idx;
    logic [IDX_W-1:0]    wr_idx_d;
    logic                wr_ok_d;
    logic [DATA_W-1:0]   wr_data_d, wr_mask_d;
    logic [STRB_W-1:0]   wr_strb_d;

    assign aw_idx = AWADDR[OFF_W +: IDX_W];
    assign ar_idx = ARADDR[OFF_W +: IDX_W];
    assign aw_ok  = (AWADDR[ADDR_W-1:OFF_W+IDX_W] == '0);
    assign ar_ok  = (ARADDR[ADDR_W-1:OFF_W+IDX_W] == '0);

    // READYs are forced low for the whole time reset is asserted
    assign AWREADY = ~ARESET & (w_state_q == W_IDLE) & tx_en[4] & ~aw_held_q;
    assign WREADY  = ~ARESET & (w_state_q == W_IDLE) & tx_en[3] & ~w_held_q;
    assign ARREADY = ~ARESET & (r_state_q == R_IDLE) & tx_en[1];
    assign BVALID  = (w_state_q == W_RESP) & (b_stuck_q | tx_en[2]);
    assign RVALID  = (r_state_q == R_DATA) & (r_stuck_q | tx_en[0]);

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign b_hs  = BVALID & BREADY;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs  = RVALID & RREADY;

    // The commit sees this cycle's handshake values ahead of the hold registers
    assign commit    = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_idx_d  = aw_hs ? aw_idx : aw_idx_q;
    assign wr_ok_d   = aw_hs ? aw_ok : aw_ok_q;
    assign wr_data_d = w_hs ? WDATA : wdata_q;
    assign wr_strb_d = w_hs ? WSTRB : wstrb_q;

    for (genvar b = 0; b < STRB_W; b++) begin : g_mask
        assign wr_mask_d[8*b +: 8] = {8{wr_strb_d[b]}};
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            b_stuck_q <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        aw_idx_q  <= aw_idx;
                        aw_ok_q   <= aw_ok;
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= WDATA;
                        wstrb_q  <= WSTRB;
                    end
                    if (commit) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        b_stuck_q <= 1'b0;
                        bresp_q   <= wr_ok_d ? RESP_OKAY : RESP_SLVERR;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        b_stuck_q <= 1'b0;
                        w_state_q <= W_IDLE;
                    end else if (BVALID) begin
                        b_stuck_q <= 1'b1;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mem_q <= '{default: '0};
        end else if (commit && wr_ok_d) begin
            mem_q[wr_idx_d] <= (mem_q[wr_idx_d] & ~wr_mask_d) | (wr_data_d & wr_mask_d);
        end
    end

    // A same-edge write is not visible here: the read samples the old word
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            r_stuck_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= ar_ok ? mem_q[ar_idx] : '0;
                        rresp_q   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        r_stuck_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        r_stuck_q <= 1'b0;
                        r_state_q <= R_IDLE;
                    end else if (RVALID) begin
                        r_stuck_q <= 1'b1;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            new_data_q <= '0;
            rx_aw_q    <= '0;
            rx_w_q     <= '0;
            rx_ar_q    <= '0;
        end else begin
            new_data_q <= {aw_hs, w_hs, b_hs, ar_hs, r_hs};
            if (aw_hs) rx_aw_q <= AWADDR;
            if (w_hs)  rx_w_q  <= WDATA;
            if (ar_hs) rx_ar_q <= ARADDR;
        end
    end

    assign BRESP     = bresp_q;
    assign RRESP     = rresp_q;
    assign RDATA     = rdata_q;
    assign new_data  = new_data_q;
    assign sub_rx_AW = rx_aw_q;
    assign sub_rx_W  = rx_w_q;
    assign sub_rx_AR = rx_ar_q;

endmodule

// File: tb/tb_axi_sub_responder.sv
// Directed bench for axi_sub_responder: a transaction-level reference model is
// compared against every output each cycle, plus hand-computed spot checks.
module tb_axi_sub_responder;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MEM_DEPTH = 16;
    localparam int MEM_BYTES = MEM_DEPTH * DATA_W / 8;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [ADDR_W-1:0] AWADDR = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA = '0;
    logic [7:0]        WSTRB = '0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [ADDR_W-1:0] ARADDR = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic [4:0]        tx_en = 5'h1F;
    logic [4:0]        new_data;
    logic [ADDR_W-1:0] sub_rx_AW;
    logic [DATA_W-1:0] sub_rx_W;
    logic [ADDR_W-1:0] sub_rx_AR;

    axi_sub_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .tx_en(tx_en), .new_data(new_data),
        .sub_rx_AW(sub_rx_AW), .sub_rx_W(sub_rx_W), .sub_rx_AR(sub_rx_AR)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending-address slot, a pending-data slot, one
    // outstanding write response and one outstanding read beat.
    logic [63:0] m_mem [MEM_DEPTH];
    logic        m_aw_have, m_w_have;
    logic [31:0] m_aw_addr;
    logic [63:0] m_w_data;
    logic [7:0]  m_w_strb;
    logic        m_b_pend, m_b_shown;
    logic [1:0]  m_b_resp;
    logic        m_r_pend, m_r_shown;
    logic [63:0] m_r_data;
    logic [1:0]  m_r_resp;
    logic [4:0]  m_nd;
    logic [31:0] m_rx_aw, m_rx_ar;
    logic [63:0] m_rx_w;

    function automatic logic e_awready();
        return !ARESET && !m_b_pend && tx_en[4] && !m_aw_have;
    endfunction
    function automatic logic e_wready();
        return !ARESET && !m_b_pend && tx_en[3] && !m_w_have;
    endfunction
    function automatic logic e_arready();
        return !ARESET && !m_r_pend && tx_en[1];
    endfunction
    function automatic logic e_bvalid();
        return m_b_pend && (m_b_shown || tx_en[2]);
    endfunction
    function automatic logic e_rvalid();
        return m_r_pend && (m_r_shown || tx_en[0]);
    endfunction

    always @(posedge ACLK or posedge ARESET) begin
        logic aw, w, b, ar, r, bv, rv;
        if (ARESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = '0;
            m_aw_have = 0; m_w_have = 0; m_aw_addr = '0; m_w_data = '0; m_w_strb = '0;
            m_b_pend = 0; m_b_shown = 0; m_b_resp = 2'b00;
            m_r_pend = 0; m_r_shown = 0; m_r_data = '0; m_r_resp = 2'b00;
            m_nd = '0; m_rx_aw = '0; m_rx_ar = '0; m_rx_w = '0;
        end else begin
            aw = AWVALID && e_awready();
            w  = WVALID && e_wready();
            ar = ARVALID && e_arready();
            bv = e_bvalid();
            rv = e_rvalid();
            b  = bv && BREADY;
            r  = rv && RREADY;
            m_nd = {aw, w, b, ar, r};
            if (ar) begin
                m_r_pend = 1; m_r_shown = 0; m_rx_ar = ARADDR;
                if (ARADDR < MEM_BYTES) begin
                    m_r_data = m_mem[int'(ARADDR >> 3)]; m_r_resp = 2'b00;
                end else begin
                    m_r_data = '0; m_r_resp = 2'b10;
                end
            end else if (r) m_r_pend = 0;
            else if (rv) m_r_shown = 1;
            if (aw) begin m_aw_have = 1; m_aw_addr = AWADDR; m_rx_aw = AWADDR; end
            if (w)  begin m_w_have = 1; m_w_data = WDATA; m_w_strb = WSTRB; m_rx_w = WDATA; end
            if (b) m_b_pend = 0;
            else if (bv) m_b_shown = 1;
            if (m_aw_have && m_w_have) begin
                if (m_aw_addr < MEM_BYTES) begin
                    for (int k = 0; k < 8; k++)
                        if (m_w_strb[k]) m_mem[int'(m_aw_addr >> 3)][8*k +: 8] = m_w_data[8*k +: 8];
                    m_b_resp = 2'b00;
                end else m_b_resp = 2'b10;
                m_aw_have = 0; m_w_have = 0;
                m_b_pend = 1; m_b_shown = 0;
            end
        end
    end

    always @(negedge ACLK) begin
        if (chk_en) begin
            chk("AWREADY", AWREADY, e_awready());
            chk("WREADY", WREADY, e_wready());
            chk("ARREADY", ARREADY, e_arready());
            chk("BVALID", BVALID, e_bvalid());
            chk("RVALID", RVALID, e_rvalid());
            chk("BRESP", BRESP, m_b_resp);
            chk("RRESP", RRESP, m_r_resp);
            chk("RDATA", RDATA, m_r_data);
            chk("new_data", new_data, m_nd);
            chk("sub_rx_AW", sub_rx_AW, m_rx_aw);
            chk("sub_rx_W", sub_rx_W, m_rx_w);
            chk("sub_rx_AR", sub_rx_AR, m_rx_ar);
        end
    end

    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        #1;
        while (!BVALID && n < 20) begin step(); #1; n++; end
        chk("bvalid_seen", BVALID, 1'b1);
        resp = BRESP;
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        wait_b(resp);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        #1;
        while (!RVALID && n < 20) begin step(); #1; n++; end
        chk("rvalid_seen", RVALID, 1'b1);
        d = RDATA; resp = RRESP;
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  rs;

        @(posedge ACLK);
        #1 chk_en = 1'b1;
        repeat (3) step();
        #1;
        chk("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
        chk("rst_valids", {BVALID, RVALID}, 2'b00);
        chk("rst_new_data", new_data, 5'b00000);
        chk("rst_rdata", RDATA, 64'h0);
        ARESET = 1'b0;
        step();

        // AW and W together
        AWADDR = 32'h08; AWVALID = 1'b1;
        WDATA = 64'hDEAD_BEEF_0000_0001; WSTRB = 8'hFF; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        #1;
        chk("t1_bvalid", BVALID, 1'b1);
        chk("t1_bresp", BRESP, 2'b00);
        chk("t1_nd_aw_w", new_data, 5'b11000);
        chk("t1_rx_w", sub_rx_W, 64'hDEAD_BEEF_0000_0001);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        #1;
        chk("t1_nd_b", new_data, 5'b00100);
        chk("t1_bvalid_low", BVALID, 1'b0);

        // W first, AW two cycles later
        WDATA = 64'h0123_4567_89AB_CDEF; WSTRB = 8'hFF; WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        #1;
        chk("t2_wready_held", WREADY, 1'b0);
        chk("t2_awready", AWREADY, 1'b1);
        step();
        AWADDR = 32'h10; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        #1;
        chk("t2_bvalid", BVALID, 1'b1);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        do_read(32'h10, d, rs);
        chk("t2_rdata", d, 64'h0123_4567_89AB_CDEF);
        chk("t2_rresp", rs, 2'b00);

        // Partial strobe
        do_write(32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rs);
        do_write(32'h18, 64'h0, 8'h0F, rs);
        do_read(32'h18, d, rs);
        chk("t3_strobe", d, 64'hFFFF_FFFF_0000_0000);

        // Out of range
        do_write(32'h1000, 64'h5555_AAAA_5555_AAAA, 8'hFF, rs);
        chk("t4_bresp", rs, 2'b10);
        do_read(32'h0, d, rs);
        chk("t4_word0", d, 64'h0);
        do_read(32'h1000, d, rs);
        chk("t4_rdata", d, 64'h0);
        chk("t4_rresp", rs, 2'b10);

        // B gated by tx_en[2], then sticky once shown
        tx_en = 5'h1B;
        AWADDR = 32'h28; AWVALID = 1'b1; WDATA = 64'h77; WSTRB = 8'hFF; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        repeat (3) begin
            #1 chk("t5_b_gated", BVALID, 1'b0);
            step();
        end
        tx_en = 5'h1F;
        #1 chk("t5_b_on", BVALID, 1'b1);
        step();
        tx_en = 5'h1B;
        #1 chk("t5_b_sticky1", BVALID, 1'b1);
        step();
        #1 chk("t5_b_sticky2", BVALID, 1'b1);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        #1 chk("t5_b_done", BVALID, 1'b0);
        tx_en = 5'h1F;

        // Second AW refused while the first is held
        AWADDR = 32'h30; AWVALID = 1'b1;
        step();
        AWADDR = 32'h38;
        #1;
        chk("t6_awready_held", AWREADY, 1'b0);
        chk("t6_rx_aw", sub_rx_AW, 32'h30);
        step();
        step();
        WDATA = 64'h6666_0000_1111_2222; WSTRB = 8'hFF; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        #1;
        chk("t6_rx_aw_kept", sub_rx_AW, 32'h30);
        chk("t6_bvalid", BVALID, 1'b1);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        do_read(32'h30, d, rs);
        chk("t6_read30", d, 64'h6666_0000_1111_2222);
        do_read(32'h38, d, rs);
        chk("t6_read38", d, 64'h0);

        // Write commit and AR on the same edge
        do_write(32'h20, 64'hAAAA_0000_0000_0001, 8'hFF, rs);
        AWADDR = 32'h20; AWVALID = 1'b1;
        WDATA = 64'hBBBB_0000_0000_0002; WSTRB = 8'hFF; WVALID = 1'b1;
        ARADDR = 32'h20; ARVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        #1;
        chk("t7_old_value", RDATA, 64'hAAAA_0000_0000_0001);
        chk("t7_rvalid", RVALID, 1'b1);
        chk("t7_bvalid", BVALID, 1'b1);
        BREADY = 1'b1; RREADY = 1'b1;
        step();
        BREADY = 1'b0; RREADY = 1'b0;
        do_read(32'h20, d, rs);
        chk("t7_new_value", d, 64'hBBBB_0000_0000_0002);

        // Reset while a read beat is offered
        ARADDR = 32'h08; ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        #1;
        chk("t8_rvalid", RVALID, 1'b1);
        chk("t8_rdata", RDATA, 64'hDEAD_BEEF_0000_0001);
        ARESET = 1'b1;
        #1;
        chk("t8_rvalid_async", RVALID, 1'b0);
        chk("t8_rdata_async", RDATA, 64'h0);
        chk("t8_arready_rst", ARREADY, 1'b0);
        step();
        step();
        ARESET = 1'b0;
        step();
        #1 chk("t8_no_rvalid", RVALID, 1'b0);
        do_read(32'h08, d, rs);
        chk("t8_mem_cleared", d, 64'h0);

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
